// File: rtl/bounds_range_table.sv
// Circular range table with free-by-base and a one-cycle eligible-range lookup.
// Define BOUNDS_RANGE_TABLE_NEWEST_FIRST_EN to report the most recently written hit instead of the lowest index.
module bounds_range_table #(
  parameter int DEPTH    = 16,
  parameter int AW       = 32,
  parameter int MIN_SIZE = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [AW-1:0]              wr_first_i,
  input  logic [AW-1:0]              wr_last_i,
  input  logic                       free_en_i,
  input  logic [AW-1:0]              free_addr_i,
  input  logic                       lookup_valid_i,
  input  logic [AW-1:0]              lookup_addr_i,
  output logic                       lookup_valid_o,
  output logic                       hit_o,
  output logic [$clog2(DEPTH)-1:0]   hit_idx_o,
  output logic [AW-1:0]              hit_first_o,
  output logic [AW-1:0]              hit_last_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       overflow_o,
  output logic [AW-1:0]              last_first_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    mem_first [DEPTH];
  logic [AW-1:0]    mem_last  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_nxt;
  logic [IW-1:0]    wr_ptr_q;
  logic             overflow_q;
  logic [AW-1:0]    last_first_q;
  logic             wr_ok;
  logic [CW-1:0]    count;

  logic [DEPTH-1:0] elig_p0;
  logic             sel_hit_p0;
  logic [IW-1:0]    sel_idx_p0;

  logic             vld_p1;
  logic             hit_p1;
  logic [IW-1:0]    hit_idx_p1;
  logic [AW-1:0]    hit_first_p1;
  logic [AW-1:0]    hit_last_p1;

  function automatic logic is_eligible(input logic [AW-1:0] first, input logic [AW-1:0] last,
                                       input logic [AW-1:0] addr);
    logic [AW-1:0] span;
    span = last - first;
    return (first <= addr) && (addr <= last) && (span > AW'(MIN_SIZE));
  endfunction

  // p0: eligibility and priority select against the state before this edge
  always_comb begin
    elig_p0    = '0;
    sel_idx_p0 = '0;
    for (int i = 0; i < DEPTH; i++)
      elig_p0[i] = valid_q[i] && is_eligible(mem_first[i], mem_last[i], lookup_addr_i);
`ifdef BOUNDS_RANGE_TABLE_NEWEST_FIRST_EN
    for (int k = DEPTH; k >= 1; k--)
      if (elig_p0[wr_ptr_q - IW'(k)]) sel_idx_p0 = wr_ptr_q - IW'(k);
`else
    for (int i = DEPTH-1; i >= 0; i--)
      if (elig_p0[i]) sel_idx_p0 = IW'(i);
`endif
  end

  assign sel_hit_p0 = |elig_p0;
  assign wr_ok      = wr_en_i && (wr_last_i >= wr_first_i);

  // Free matches pre-write state; a same-cycle write always leaves its slot valid.
  always_comb begin
    valid_nxt = valid_q;
    if (free_en_i)
      for (int i = 0; i < DEPTH; i++)
        if (valid_q[i] && (mem_first[i] == free_addr_i)) valid_nxt[i] = 1'b0;
    if (wr_ok) valid_nxt[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(valid_q[i]);
  end

  // p1: registered table state and lookup result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_first[i] <= '0;
        mem_last[i]  <= '0;
      end
      valid_q      <= '0;
      wr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      last_first_q <= '0;
      vld_p1       <= 1'b0;
      hit_p1       <= 1'b0;
      hit_idx_p1   <= '0;
      hit_first_p1 <= '0;
      hit_last_p1  <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_first[i] <= '0;
        mem_last[i]  <= '0;
      end
      valid_q      <= '0;
      wr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      last_first_q <= '0;
      vld_p1       <= 1'b0;
      hit_p1       <= 1'b0;
      hit_idx_p1   <= '0;
      hit_first_p1 <= '0;
      hit_last_p1  <= '0;
    end else begin
      valid_q <= valid_nxt;
      if (wr_ok) begin
        mem_first[wr_ptr_q] <= wr_first_i;
        mem_last[wr_ptr_q]  <= wr_last_i;
        wr_ptr_q            <= wr_ptr_q + IW'(1);
        last_first_q        <= wr_first_i;
        if (valid_q[wr_ptr_q]) overflow_q <= 1'b1;
      end
      vld_p1 <= lookup_valid_i;
      if (lookup_valid_i) begin
        hit_p1       <= sel_hit_p0;
        hit_idx_p1   <= sel_hit_p0 ? sel_idx_p0 : '0;
        hit_first_p1 <= sel_hit_p0 ? mem_first[sel_idx_p0] : '0;
        hit_last_p1  <= sel_hit_p0 ? mem_last[sel_idx_p0] : '0;
      end
    end
  end

  assign lookup_valid_o = vld_p1;
  assign hit_o          = hit_p1;
  assign hit_idx_o      = hit_idx_p1;
  assign hit_first_o    = hit_first_p1;
  assign hit_last_o     = hit_last_p1;
  assign count_o        = count;
  assign full_o         = (count == CW'(DEPTH));
  assign overflow_o     = overflow_q;
  assign last_first_o   = last_first_q;

endmodule

// File: tb/tb_bounds_range_table.sv
// Directed bench for bounds_range_table (DEPTH=4, MIN_SIZE=20) with a per-cycle reference model.
module tb_bounds_range_table;
  localparam int DEPTH    = 4;
  localparam int AW       = 32;
  localparam int MIN_SIZE = 20;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i, wr_en_i, free_en_i, lookup_valid_i;
  logic [AW-1:0] wr_first_i, wr_last_i, free_addr_i, lookup_addr_i;
  logic          lookup_valid_o, hit_o, full_o, overflow_o;
  logic [1:0]    hit_idx_o;
  logic [AW-1:0] hit_first_o, hit_last_o, last_first_o;
  logic [2:0]    count_o;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  bounds_range_table #(.DEPTH(DEPTH), .AW(AW), .MIN_SIZE(MIN_SIZE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .wr_en_i(wr_en_i), .wr_first_i(wr_first_i), .wr_last_i(wr_last_i),
    .free_en_i(free_en_i), .free_addr_i(free_addr_i),
    .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i),
    .lookup_valid_o(lookup_valid_o), .hit_o(hit_o), .hit_idx_o(hit_idx_o),
    .hit_first_o(hit_first_o), .hit_last_o(hit_last_o),
    .count_o(count_o), .full_o(full_o), .overflow_o(overflow_o),
    .last_first_o(last_first_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a list of ranges with write order, slot = writes mod DEPTH.
  bit [31:0] m_first [DEPTH];
  bit [31:0] m_last  [DEPTH];
  bit        m_valid [DEPTH];
  int        m_seq   [DEPTH];
  int        m_wcount;
  bit        m_ovf, m_lv, m_hit;
  bit [31:0] m_lastfirst, m_hf, m_hl;
  int        m_idx;

  function automatic int find_hit(input bit [31:0] a);
    int best = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_first[i] <= a && a <= m_last[i] && (m_last[i] - m_first[i]) > 32'(MIN_SIZE)) begin
`ifdef BOUNDS_RANGE_TABLE_NEWEST_FIRST_EN
        if (best < 0 || m_seq[i] > m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    return best;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  function automatic bit [31:0] exp_first(input bit [31:0] a);
    int h = find_hit(a);
    return (h >= 0) ? m_first[h] : 32'h0;
  endfunction

  function automatic bit [31:0] exp_last(input bit [31:0] a);
    int h = find_hit(a);
    return (h >= 0) ? m_last[h] : 32'h0;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_first[i] <= '0; m_last[i] <= '0; m_valid[i] <= 1'b0; m_seq[i] <= 0;
      end
      m_wcount <= 0; m_ovf <= 1'b0; m_lastfirst <= '0;
      m_lv <= 1'b0; m_hit <= 1'b0; m_idx <= 0; m_hf <= '0; m_hl <= '0;
    end else begin
      m_lv <= lookup_valid_i;
      if (lookup_valid_i) begin
        m_hit <= (find_hit(lookup_addr_i) >= 0);
        m_idx <= (find_hit(lookup_addr_i) >= 0) ? find_hit(lookup_addr_i) : 0;
        m_hf  <= exp_first(lookup_addr_i);
        m_hl  <= exp_last(lookup_addr_i);
      end
      if (free_en_i)
        for (int i = 0; i < DEPTH; i++)
          if (m_valid[i] && m_first[i] == free_addr_i) m_valid[i] <= 1'b0;
      if (wr_en_i && wr_last_i >= wr_first_i) begin
        if (m_valid[m_wcount % DEPTH]) m_ovf <= 1'b1;
        m_first[m_wcount % DEPTH] <= wr_first_i;
        m_last[m_wcount % DEPTH]  <= wr_last_i;
        m_valid[m_wcount % DEPTH] <= 1'b1;
        m_seq[m_wcount % DEPTH]   <= m_wcount;
        m_wcount    <= m_wcount + 1;
        m_lastfirst <= wr_first_i;
      end
    end
  end

  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("mon_lookup_valid", lookup_valid_o, m_lv);
      chk("mon_hit", hit_o, m_hit);
      chk("mon_hit_idx", hit_idx_o, m_idx);
      chk("mon_hit_first", hit_first_o, m_hf);
      chk("mon_hit_last", hit_last_o, m_hl);
      chk("mon_count", count_o, m_count());
      chk("mon_full", full_o, m_count() == DEPTH);
      chk("mon_overflow", overflow_o, m_ovf);
      chk("mon_last_first", last_first_o, m_lastfirst);
    end
  end

  task automatic step(input bit clr, input bit wr, input bit [31:0] wf, input bit [31:0] wl,
                      input bit fr, input bit [31:0] fa, input bit lk, input bit [31:0] la);
    clear_i = clr; wr_en_i = wr; wr_first_i = wf; wr_last_i = wl;
    free_en_i = fr; free_addr_i = fa; lookup_valid_i = lk; lookup_addr_i = la;
    @(posedge clk_i);
    #1;
    clear_i = 0; wr_en_i = 0; free_en_i = 0; lookup_valid_i = 0;
  endtask

  task automatic wr(input bit [31:0] f, input bit [31:0] l);
    step(0, 1, f, l, 0, 0, 0, 0);
  endtask
  task automatic lk(input bit [31:0] a);
    step(0, 0, 0, 0, 0, 0, 1, a);
  endtask
  task automatic fr(input bit [31:0] a);
    step(0, 0, 0, 0, 1, a, 0, 0);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 0; wr_en_i = 0; free_en_i = 0; lookup_valid_i = 0;
    wr_first_i = 0; wr_last_i = 0; free_addr_i = 0; lookup_addr_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    #1;
    chk("reset_count", count_o, 0);
    chk("reset_lookup_valid", lookup_valid_o, 0);
    chk("reset_overflow", overflow_o, 0);
    chk("reset_last_first", last_first_o, 0);
    chk("reset_hit", hit_o, 0);

    wr(32'h1000, 32'h10FF);
    lk(32'h1080);
    chk("basic_valid", lookup_valid_o, 1);
    chk("basic_hit", hit_o, 1);
    chk("basic_idx", hit_idx_o, 0);
    chk("basic_first", hit_first_o, 32'h1000);
    chk("basic_last", hit_last_o, 32'h10FF);
    chk("basic_count", count_o, 1);
    chk("basic_last_first", last_first_o, 32'h1000);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("hold_valid_low", lookup_valid_o, 0);
    chk("hold_hit", hit_o, 1);
    chk("hold_first", hit_first_o, 32'h1000);

    wr(32'h2000, 32'h2010);
    lk(32'h2008);
    chk("small_range_hit", hit_o, 0);
    chk("small_range_first", hit_first_o, 0);
    chk("small_range_count", count_o, 2);
    lk(32'h10FF);
    chk("upper_bound_hit", hit_o, 1);
    lk(32'h1100);
    chk("past_bound_hit", hit_o, 0);
    wr(32'h3000, 32'h2FFF);
    chk("bad_write_count", count_o, 2);
    chk("bad_write_last_first", last_first_o, 32'h2000);

    step(1, 1, 32'h7000, 32'h70FF, 0, 0, 0, 0);
    chk("clear_write_count", count_o, 0);
    chk("clear_write_last_first", last_first_o, 0);

    for (int k = 1; k <= 4; k++) wr(32'(k) << 12, (32'(k) << 12) + 32'hFF);
    chk("fill_full", full_o, 1);
    chk("fill_overflow", overflow_o, 0);
    wr(32'h5000, 32'h50FF);
    chk("wrap_count", count_o, 4);
    chk("wrap_full", full_o, 1);
    chk("wrap_overflow", overflow_o, 1);
    lk(32'h5080);
    chk("wrap_idx", hit_idx_o, 0);
    chk("wrap_first", hit_first_o, 32'h5000);
    lk(32'h1080);
    chk("wrap_old_miss", hit_o, 0);

    fr(32'h2000);
    chk("free_count", count_o, 3);
    chk("free_full", full_o, 0);
    lk(32'h2080);
    chk("free_miss", hit_o, 0);
    fr(32'h9999);
    chk("free_nomatch_count", count_o, 3);
    step(0, 1, 32'h2000, 32'h20FF, 1, 32'h2000, 0, 0);
    chk("wr_free_count", count_o, 4);
    lk(32'h2080);
    chk("wr_free_hit", hit_o, 1);
    chk("wr_free_idx", hit_idx_o, 1);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    wr(32'h1000, 32'h1FFF);
    wr(32'h1800, 32'h18FF);
    lk(32'h1880);
`ifdef BOUNDS_RANGE_TABLE_NEWEST_FIRST_EN
    chk("overlap_idx", hit_idx_o, 1);
    chk("overlap_first", hit_first_o, 32'h1800);
`else
    chk("overlap_idx", hit_idx_o, 0);
    chk("overlap_first", hit_first_o, 32'h1000);
`endif
    step(0, 1, 32'h3000, 32'h30FF, 0, 0, 1, 32'h3080);
    chk("same_cycle_write_miss", hit_o, 0);
    lk(32'h3080);
    chk("after_write_hit", hit_o, 1);
    chk("after_write_idx", hit_idx_o, 2);

    lookup_valid_i = 1; lookup_addr_i = 32'h1080;
    @(posedge clk_i);
    #1;
    lookup_valid_i = 0;
    chk("pre_reset_valid", lookup_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("async_reset_valid", lookup_valid_o, 0);
    chk("async_reset_count", count_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
